// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// byte receive with valid pulse and byte transmit with request pulse.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  output logic                  rw,
  output logic                  busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   sda_rise;
  logic                   sda_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]  shift, shift_nxt;
  logic                   phase, phase_nxt;
  logic                   sda_oe, sda_oe_nxt;
  logic [DATA_WIDTH-1:0]  rx_data_nxt;
  logic                   rx_valid_nxt;
  logic                   tx_req_nxt;
  logic                   rw_nxt;
  logic                   busy_nxt;

  // Open-drain data line: only ever pulled low
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronise both bus lines and keep one history flop for edge strobes
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  assign start_det = sda_fall & scl_s & scl_d;
  assign stop_det  = sda_rise & scl_s & scl_d;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      phase    <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      phase    <= phase_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_req   <= tx_req_nxt;
      rw       <= rw_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state logic; START/STOP take priority over bit handling.
  // phase marks the second half of an ACK slot (drive done, release pending).
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    phase_nxt    = phase;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    rw_nxt       = rw;
    busy_nxt     = busy;

    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      phase_nxt   = 1'b0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      phase_nxt   = 1'b0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sda_oe_nxt = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[DATA_WIDTH-2:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == '1) begin
              if (shift[DATA_WIDTH-2:0] == SLAVE_ADDR) begin
                rw_nxt    = sda_s;
                phase_nxt = 1'b0;
                state_nxt = ADDR_ACK;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = WAIT_STOP;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              tx_req_nxt = rw;
              phase_nxt  = 1'b1;
            end else begin
              phase_nxt   = 1'b0;
              bit_cnt_nxt = '0;
              if (rw) begin
                shift_nxt  = tx_data;
                sda_oe_nxt = ~tx_data[DATA_WIDTH-1];
                state_nxt  = RD_DATA;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_nxt   = {shift[DATA_WIDTH-2:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == '1) begin
              rx_data_nxt  = {shift[DATA_WIDTH-2:0], sda_s};
              rx_valid_nxt = 1'b1;
              phase_nxt    = 1'b0;
              state_nxt    = WR_ACK;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_nxt = 1'b1;
              phase_nxt  = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              phase_nxt  = 1'b0;
              state_nxt  = WR_DATA;
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == '1) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              phase_nxt   = 1'b0;
              state_nxt   = RD_ACK;
            end else begin
              shift_nxt   = {shift[DATA_WIDTH-2:0], 1'b0};
              sda_oe_nxt  = ~shift[DATA_WIDTH-2];
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end

        RD_ACK: begin
          if (!phase && scl_rise) begin
            if (!sda_s) begin
              tx_req_nxt = 1'b1;
              phase_nxt  = 1'b1;
            end else begin
              state_nxt = WAIT_STOP;
            end
          end else if (phase && scl_fall) begin
            shift_nxt   = tx_data;
            sda_oe_nxt  = ~tx_data[DATA_WIDTH-1];
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            state_nxt   = RD_DATA;
          end
        end

        WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
        end

        default: begin
          sda_oe_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master model, table of write
// transactions plus hand sequences for read, repeated START, STOP mid-byte
// and reset mid-read.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int unsigned Q = 10;  // system clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       arst;
  logic       scl_m;
  logic       sda_m_oe;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       rw;
  logic       busy;

  pullup (sda);
  assign sda = sda_m_oe ? 1'b0 : 1'bz;

  i2c_slave #(
    .SLAVE_ADDR (7'h50),
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .scl     (scl_m),
    .sda     (sda),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rw      (rw),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         rx_cnt = 0;
  int         req_cnt = 0;
  logic [7:0] tx_q[$];
  logic       busy_watch = 1'b0;
  logic       busy_drop  = 1'b0;

  // User-side responder: count pulses and hand out read bytes on request
  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_req) begin
      req_cnt++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      else tx_data = 8'hEE;
    end
    if (busy_watch && !busy) busy_drop = 1'b1;
  end

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m_oe = 1'b0; wait_q();
    sda_m_oe = 1'b1; wait_q();
    scl_m    = 1'b0; wait_q();
  endtask

  task automatic bus_rstart();
    sda_m_oe = 1'b0; wait_q();
    scl_m    = 1'b1; wait_q();
    sda_m_oe = 1'b1; wait_q();
    scl_m    = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m_oe = 1'b1; wait_q();
    scl_m    = 1'b1; wait_q();
    sda_m_oe = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m_oe = ~b; wait_q();
    scl_m    = 1'b1; wait_q();
    s        = sda; wait_q();
    scl_m    = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~m_ack, s);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       addr_ack;
    logic       data_ack;
    int         rx_inc;
    logic       busy_mid;
  } wvec_t;

  wvec_t vec[5];

  initial begin
    logic       a;
    logic       s;
    logic [7:0] d;
    logic [7:0] model_rx;
    int         r0;
    int         r1;

    vec[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 1'b1};
    vec[1] = '{8'hA2, 8'h55, 1'b0, 1'b0, 0, 1'b0};
    vec[2] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1, 1'b1};
    vec[3] = '{8'h20, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    vec[4] = '{8'hA0, 8'h81, 1'b1, 1'b1, 1, 1'b1};
    model_rx = 8'h00;

    arst     = 1'b0;
    scl_m    = 1'b1;
    sda_m_oe = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_tx_req", tx_req, 1'b0);
    chk("reset_rw", rw, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sda", sda, 1'b1);
    arst = 1'b1;
    wait_q();

    // Single-byte writes, matching and non-matching addresses
    for (int k = 0; k < 5; k++) begin
      r0 = rx_cnt;
      bus_start();
      write_byte(vec[k].addr, a);
      chk($sformatf("v%0d_addr_ack", k), a, vec[k].addr_ack);
      write_byte(vec[k].data, a);
      chk($sformatf("v%0d_data_ack", k), a, vec[k].data_ack);
      chk($sformatf("v%0d_busy_mid", k), busy, vec[k].busy_mid);
      chk($sformatf("v%0d_rw", k), rw, 1'b0);
      bus_stop();
      wait_q();
      if (vec[k].rx_inc != 0) model_rx = vec[k].data;
      chk($sformatf("v%0d_rx_pulses", k), rx_cnt - r0, vec[k].rx_inc);
      chk($sformatf("v%0d_rx_data", k), rx_data, model_rx);
      chk($sformatf("v%0d_busy_after_stop", k), busy, 1'b0);
    end

    // Read two bytes: master ACKs the first, NACKs the second
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h0F);
    r1 = req_cnt;
    bus_start();
    write_byte(8'hA1, a);
    chk("rd_addr_ack", a, 1'b1);
    chk("rd_rw", rw, 1'b1);
    chk("rd_busy", busy, 1'b1);
    read_byte(1'b1, d);
    chk("rd_byte0", d, 8'h96);
    read_byte(1'b0, d);
    chk("rd_byte1", d, 8'h0F);
    chk("rd_tx_req_pulses", req_cnt - r1, 2);
    chk("rd_sda_released_after_nack", sda, 1'b1);
    chk("rd_busy_wait_stop", busy, 1'b1);
    bus_stop();
    wait_q();
    chk("rd_busy_after_stop", busy, 1'b0);

    // Write then repeated START into a one-byte read
    r0 = rx_cnt;
    r1 = req_cnt;
    tx_q.push_back(8'h5A);
    bus_start();
    write_byte(8'hA0, a);
    chk("sr_wr_addr_ack", a, 1'b1);
    chk("sr_rw_write", rw, 1'b0);
    busy_watch = 1'b1;
    write_byte(8'h11, a);
    chk("sr_wr_data_ack", a, 1'b1);
    bus_rstart();
    write_byte(8'hA1, a);
    chk("sr_rd_addr_ack", a, 1'b1);
    chk("sr_rw_read", rw, 1'b1);
    read_byte(1'b0, d);
    chk("sr_rd_byte", d, 8'h5A);
    busy_watch = 1'b0;
    chk("sr_busy_held", busy_drop, 1'b0);
    model_rx = 8'h11;
    chk("sr_rx_pulses", rx_cnt - r0, 1);
    chk("sr_rx_data", rx_data, model_rx);
    chk("sr_tx_req_pulses", req_cnt - r1, 1);
    bus_stop();
    wait_q();
    chk("sr_busy_after_stop", busy, 1'b0);

    // STOP in the middle of a data byte
    r0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, a);
    chk("ms_addr_ack", a, 1'b1);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    bus_stop();
    wait_q();
    chk("ms_rx_pulses", rx_cnt - r0, 0);
    chk("ms_rx_data", rx_data, model_rx);
    chk("ms_busy", busy, 1'b0);
    chk("ms_sda_released", sda, 1'b1);

    // Reset while the target drives bit 0 of a 0x00 read byte
    tx_q.push_back(8'h00);
    bus_start();
    write_byte(8'hA1, a);
    chk("rr_addr_ack", a, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, s);
    chk("rr_bit0_driven", sda, 1'b0);
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    chk("rr_sda_released", sda, 1'b1);
    chk("rr_rx_data", rx_data, 8'h00);
    chk("rr_rx_valid", rx_valid, 1'b0);
    chk("rr_tx_req", tx_req, 1'b0);
    chk("rr_rw", rw, 1'b0);
    chk("rr_busy", busy, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    model_rx = 8'h00;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    wait_q();
    bus_start();
    write_byte(8'hA0, a);
    chk("rr_after_addr_ack", a, 1'b1);
    write_byte(8'h77, a);
    chk("rr_after_data_ack", a, 1'b1);
    bus_stop();
    wait_q();
    model_rx = 8'h77;
    chk("rr_after_rx_data", rx_data, model_rx);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
